mandelbrot_pixel_engine: RTL



---
 rtl/mandelbrot_pkg.sv | 9 +
 rtl/mandelbrot_pixel_engine_if.sv | 27 ++
 rtl/mandelbrot_iter.sv | 34 +++
 rtl/mandelbrot_pixel_engine.sv | 70 +++++++
 4 files changed

// File: rtl/mandelbrot_pkg.sv
// mandelbrot_pkg: shared widths, escape threshold and FSM states for the mandelbrot pixel engine
package mandelbrot_pkg;
  localparam int WIDTH = 20;
  localparam int FRAC_BITS = 10;
  localparam int ITER_W = 8;
  localparam int TAG_W = 19;
  localparam logic signed [WIDTH-1:0] ESCAPE_SQ = 20'sh01000;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/mandelbrot_pixel_engine_if.sv
// mandelbrot_pixel_engine_if: job input and result output handshakes of the pixel engine
interface mandelbrot_pixel_engine_if #(
  parameter int WIDTH = mandelbrot_pkg::WIDTH,
  parameter int TAG_W = mandelbrot_pkg::TAG_W,
  parameter int ITER_W = mandelbrot_pkg::ITER_W
);
  logic in_valid;
  logic in_ready;
  logic signed [WIDTH-1:0] in_c_real;
  logic signed [WIDTH-1:0] in_c_imag;
  logic [TAG_W-1:0] in_tag;
  logic [ITER_W-1:0] max_iter;
  logic out_valid;
  logic out_ready;
  logic [ITER_W-1:0] out_iters;
  logic out_escaped;
  logic [TAG_W-1:0] out_tag;
  logic busy;
  modport master (
    output in_valid, in_c_real, in_c_imag, in_tag, max_iter, out_ready,
    input in_ready, out_valid, out_iters, out_escaped, out_tag, busy
  );
  modport slave (
    input in_valid, in_c_real, in_c_imag, in_tag, max_iter, out_ready,
    output in_ready, out_valid, out_iters, out_escaped, out_tag, busy
  );
endinterface

// File: rtl/mandelbrot_iter.sv
// mandelbrot_iter: one combinational step z^2 + c in signed fixed point, plus |z|^2 of the incoming z
module mandelbrot_iter #(
  parameter int WIDTH = 20,
  parameter int FRAC_BITS = 10,
  parameter int ITER_W = 8
) (
  input  logic signed [WIDTH-1:0] z_real,
  input  logic signed [WIDTH-1:0] z_imag,
  input  logic signed [WIDTH-1:0] c_real,
  input  logic signed [WIDTH-1:0] c_imag,
  input  logic [ITER_W-1:0] iter_in,
  output logic signed [WIDTH-1:0] out_real,
  output logic signed [WIDTH-1:0] out_imag,
  output logic signed [WIDTH-1:0] size_square,
  output logic [ITER_W-1:0] iter_out
);
  logic signed [2*WIDTH-1:0] zr_x, zi_x, rr, ii, ri;
  logic signed [WIDTH-1:0] rr_s, ii_s, ri2_s;
  always_comb begin
    zr_x = $signed({{WIDTH{z_real[WIDTH-1]}}, z_real});
    zi_x = $signed({{WIDTH{z_imag[WIDTH-1]}}, z_imag});
    rr = zr_x * zr_x;
    ii = zi_x * zi_x;
    ri = zr_x * zi_x;
    rr_s = rr[WIDTH+FRAC_BITS-1:FRAC_BITS];
    ii_s = ii[WIDTH+FRAC_BITS-1:FRAC_BITS];
    // taking the slice one bit lower yields 2*zr*zi without losing the lsb
    ri2_s = ri[WIDTH+FRAC_BITS-2:FRAC_BITS-1];
    out_real = rr_s - ii_s + c_real;
    out_imag = ri2_s + c_imag;
    size_square = rr_s + ii_s;
    iter_out = iter_in + ITER_W'(1);
  end
endmodule

// File: rtl/mandelbrot_pixel_engine.sv
// mandelbrot_pixel_engine: iterates one pixel per job, one mandelbrot step per clock,
// and returns the iteration count at escape or at the latched limit.
module mandelbrot_pixel_engine
  import mandelbrot_pkg::*;
#(
  parameter int WIDTH = mandelbrot_pkg::WIDTH,
  parameter int TAG_W = mandelbrot_pkg::TAG_W,
  parameter int ITER_W = mandelbrot_pkg::ITER_W
) (
  input logic clk,
  input logic rst,
  mandelbrot_pixel_engine_if.slave io
);
  state_t state, state_nxt;
  logic signed [WIDTH-1:0] zr, zi, cr, ci, nr, ni, sq;
  logic [ITER_W-1:0] iters, iter_nxt, max_l, res;
  logic [TAG_W-1:0] tag;
  logic esc, accept, escape, at_max;
  mandelbrot_iter #(.WIDTH(WIDTH), .FRAC_BITS(FRAC_BITS), .ITER_W(ITER_W)) u_iter (
    .z_real(zr), .z_imag(zi), .c_real(cr), .c_imag(ci), .iter_in(iters),
    .out_real(nr), .out_imag(ni), .size_square(sq), .iter_out(iter_nxt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nxt;
  // a negative square means the product wrapped, which only happens far outside the set
  always_comb begin
    escape = sq[WIDTH-1] || (sq >= ESCAPE_SQ);
    at_max = iters == max_l;
    io.in_ready = (state == IDLE) || (state == DONE && io.out_ready);
    accept = io.in_valid && io.in_ready;
    io.out_valid = state == DONE;
    io.busy = state != IDLE;
    state_nxt = accept ? RUN :
                (state == RUN && (escape || at_max)) ? DONE :
                (state == DONE && io.out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      zr <= '0;
      zi <= '0;
      cr <= '0;
      ci <= '0;
      iters <= '0;
      max_l <= '0;
      tag <= '0;
      res <= '0;
      esc <= 1'b0;
    end else if (accept) begin
      cr <= io.in_c_real;
      ci <= io.in_c_imag;
      tag <= io.in_tag;
      max_l <= io.max_iter;
      zr <= '0;
      zi <= '0;
      iters <= '0;
    end else if (state == RUN) begin
      if (escape || at_max) begin
        res <= iters;
        esc <= escape;
      end else begin
        zr <= nr;
        zi <= ni;
        iters <= iter_nxt;
      end
    end
  assign io.out_iters = res;
  assign io.out_escaped = esc;
  assign io.out_tag = tag;
endmodule
